// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: MUL/DIVU/REMU sequencer that borrows the shared ALU one add, sub or sltu per cycle
module muldiv_sequencer #(
  parameter logic [3:0] OP_ADD  = 4'b0010,
  parameter logic [3:0] OP_SUB  = 4'b0110,
  parameter logic [3:0] OP_SLTU = 4'b0111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op_sel,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result
);
  typedef enum logic [2:0] {IDLE, MUL_ITER, DIV_CMP, DIV_SUB, DONE} state_t;
  state_t state, state_n;
  logic [4:0]  cnt;
  logic [1:0]  op;
  logic [31:0] acc, sh, q;
  logic        lt;
  logic [31:0] shifted;
  logic        last;
  // acc holds product/remainder, sh holds mcand/divisor, q holds mplier/quotient
  assign shifted = {acc[30:0], q[31]};
  assign last = cnt == 5'd31;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    alu_op = OP_ADD;
    alu_opA = '0;
    alu_opB = '0;
    case (state)
      IDLE: if (start && !flush) state_n = op_sel == 2'b00 ? MUL_ITER : op_sel == 2'b11 ? DONE : DIV_CMP;
      MUL_ITER: begin
        alu_opA = acc;
        alu_opB = q[0] ? sh : '0;
        state_n = last ? DONE : MUL_ITER;
      end
      DIV_CMP: begin
        alu_op = OP_SLTU;
        alu_opA = shifted;
        alu_opB = sh;
        state_n = DIV_SUB;
      end
      DIV_SUB: begin
        alu_op = OP_SUB;
        alu_opA = acc;
        alu_opB = lt ? '0 : sh;
        state_n = last ? DONE : DIV_CMP;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush && state != DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      op <= '0;
      acc <= '0;
      sh <= '0;
      q <= '0;
      lt <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          cnt <= '0;
          op <= op_sel;
          acc <= '0;
          sh <= op_sel == 2'b00 ? src_a : src_b;
          q <= op_sel == 2'b00 ? src_b : src_a;
          if (op_sel == 2'b11) result <= '0;
        end
        MUL_ITER: begin
          acc <= alu_result;
          sh <= sh << 1;
          q <= q >> 1;
          cnt <= cnt + 5'd1;
          if (last && !flush) result <= alu_result;
        end
        DIV_CMP: begin
          lt <= alu_result[0] & ~acc[31];
          acc <= shifted;
          q <= q << 1;
        end
        DIV_SUB: begin
          acc <= alu_result;
          q[0] <= ~lt;
          cnt <= cnt + 5'd1;
          if (last && !flush) result <= op == 2'b01 ? {q[31:1], ~lt} : alu_result;
        end
        default: ;
      endcase
    end
endmodule
